// File: rtl/masked_parallel_hpc3_array.sv
//------------------------------------------------------------------------------
// Module   : masked_parallel_hpc3_array
// Brief    : N-channel first-order HPC3 masked GF(2^BIT_WIDTH) multiplier array;
//            shared operand A times per-channel B, with valid/mask pipeline and
//            a saturating output beat counter. Optional macro
//            MASKED_PAR_SHARED_R_EN feeds one r vector to every channel.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module masked_parallel_hpc3_array #(
    parameter int NUM_SHARES   = 2,
    parameter int BIT_WIDTH    = 4,   // 1..8; field polynomial chosen below
    parameter int NUM_CHANNELS = 3,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                                          in_clock,
    input  logic                                          in_reset,
    input  logic                                          in_valid_t0,
    input  logic [NUM_CHANNELS-1:0]                       in_mask_t0,
    input  logic [NUM_CHANNELS*NUM_SHARES*BIT_WIDTH-1:0]  in_b_t0,
    input  logic [NUM_SHARES*BIT_WIDTH-1:0]               in_a_t1,
`ifdef MASKED_PAR_SHARED_R_EN
    input  logic [NUM_SHARES*(NUM_SHARES-1)/2*BIT_WIDTH-1:0]              in_r,
`else
    input  logic [NUM_CHANNELS*NUM_SHARES*(NUM_SHARES-1)/2*BIT_WIDTH-1:0] in_r,
`endif
    input  logic [NUM_CHANNELS*NUM_SHARES*(NUM_SHARES-1)/2*BIT_WIDTH-1:0] in_p,
    output logic                                          out_valid_t2,
    output logic [NUM_CHANNELS-1:0]                       out_mask_t2,
    output logic [NUM_CHANNELS*NUM_SHARES*BIT_WIDTH-1:0]  out_c_t2,
    output logic [COUNT_WIDTH-1:0]                        out_count
);

    localparam int c_num_quad  = NUM_SHARES * (NUM_SHARES - 1) / 2;
    localparam int c_share_w   = NUM_SHARES * BIT_WIDTH;
    localparam int c_rand_w    = c_num_quad * BIT_WIDTH;
    // Low-order terms of x^BIT_WIDTH for an irreducible trinomial/pentanomial
    localparam logic [7:0] c_poly_all = (BIT_WIDTH == 8) ? 8'h1B :
                                        (BIT_WIDTH == 5) ? 8'h05 : 8'h03;
    localparam logic [BIT_WIDTH-1:0] c_poly = c_poly_all[BIT_WIDTH-1:0];
    localparam logic [COUNT_WIDTH-1:0] c_count_one = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [BIT_WIDTH-1:0] gf_mul(input logic [BIT_WIDTH-1:0] a,
                                                    input logic [BIT_WIDTH-1:0] b);
        logic [BIT_WIDTH-1:0] acc;
        acc = '0;
        for (int i = BIT_WIDTH - 1; i >= 0; i--) begin
            acc = acc[BIT_WIDTH-1] ? ((acc << 1) ^ c_poly) : (acc << 1);
            if (b[i]) acc = acc ^ a;
        end
        return acc;
    endfunction

    // Index of the unordered share pair {i,j} into the r/p slices
    function automatic int pidx(input int i, input int j);
        int lo, hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * NUM_SHARES - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    logic                    r_valid_t1;
    logic [NUM_CHANNELS-1:0] r_mask_t1;
    logic                    r_out_valid;
    logic [NUM_CHANNELS-1:0] r_out_mask;
    logic [COUNT_WIDTH-1:0]  r_count;

    always_ff @(posedge in_clock or posedge in_reset) begin
        if (in_reset) begin
            r_valid_t1  <= 1'b0;
            r_mask_t1   <= '0;
            r_out_valid <= 1'b0;
            r_out_mask  <= '0;
            r_count     <= '0;
        end else begin
            r_valid_t1  <= in_valid_t0;
            r_out_valid <= r_valid_t1;
            if (in_valid_t0) r_mask_t1  <= in_mask_t0;
            if (r_valid_t1)  r_out_mask <= r_mask_t1;
            // Counter tracks beats up to and including the one now on the outputs
            if (r_valid_t1 && (r_count != '1)) r_count <= r_count + c_count_one;
        end
    end

    assign out_valid_t2 = r_out_valid;
    assign out_mask_t2  = r_out_mask;
    assign out_count    = r_count;

    generate
        for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
            logic [c_share_w-1:0] r_b;
            logic [BIT_WIDTH-1:0] r_u [NUM_SHARES][NUM_SHARES];
            logic [BIT_WIDTH-1:0] r_v [NUM_SHARES][NUM_SHARES];
            logic [c_rand_w-1:0]  w_r;
            logic [c_rand_w-1:0]  w_p;
            logic [c_share_w-1:0] w_c;

`ifdef MASKED_PAR_SHARED_R_EN
            assign w_r = in_r;
`else
            assign w_r = in_r[k*c_rand_w +: c_rand_w];
`endif
            assign w_p = in_p[k*c_rand_w +: c_rand_w];

            always_ff @(posedge in_clock or posedge in_reset) begin
                if (in_reset) begin
                    r_b <= '0;
                end else if (in_valid_t0 && in_mask_t0[k]) begin
                    r_b <= in_b_t0[k*c_share_w +: c_share_w];
                end
            end

            // Cross terms: u = a_i*(b_j^r), v = a_i*r ^ p; u^v = a_i*b_j ^ p, p cancels pairwise
            always_ff @(posedge in_clock or posedge in_reset) begin
                if (in_reset) begin
                    for (int i = 0; i < NUM_SHARES; i++) begin
                        for (int j = 0; j < NUM_SHARES; j++) begin
                            r_u[i][j] <= '0;
                            r_v[i][j] <= '0;
                        end
                    end
                end else if (r_valid_t1 && r_mask_t1[k]) begin
                    for (int i = 0; i < NUM_SHARES; i++) begin
                        for (int j = 0; j < NUM_SHARES; j++) begin
                            if (i == j) begin
                                r_u[i][j] <= gf_mul(in_a_t1[i*BIT_WIDTH +: BIT_WIDTH],
                                                    r_b[j*BIT_WIDTH +: BIT_WIDTH]);
                                r_v[i][j] <= '0;
                            end else begin
                                r_u[i][j] <= gf_mul(in_a_t1[i*BIT_WIDTH +: BIT_WIDTH],
                                                    r_b[j*BIT_WIDTH +: BIT_WIDTH] ^
                                                    w_r[pidx(i, j)*BIT_WIDTH +: BIT_WIDTH]);
                                r_v[i][j] <= gf_mul(in_a_t1[i*BIT_WIDTH +: BIT_WIDTH],
                                                    w_r[pidx(i, j)*BIT_WIDTH +: BIT_WIDTH]) ^
                                             w_p[pidx(i, j)*BIT_WIDTH +: BIT_WIDTH];
                            end
                        end
                    end
                end
            end

            always_comb begin
                w_c = '0;
                for (int i = 0; i < NUM_SHARES; i++) begin
                    for (int j = 0; j < NUM_SHARES; j++) begin
                        w_c[i*BIT_WIDTH +: BIT_WIDTH] = w_c[i*BIT_WIDTH +: BIT_WIDTH] ^
                                                        r_u[i][j] ^ r_v[i][j];
                    end
                end
                if (!r_out_mask[k]) w_c = '0;
            end

            assign out_c_t2[k*c_share_w +: c_share_w] = w_c;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_masked_parallel_hpc3_array.sv
//------------------------------------------------------------------------------
// Module   : tb_masked_parallel_hpc3_array
// Brief    : Directed bench for masked_parallel_hpc3_array (GF(2) and GF(16)
//            instances) with a recombining reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_masked_parallel_hpc3_array;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // GF(16) instance, x^4+x+1
    logic        v4;
    logic [2:0]  m4;
    logic [23:0] b4;
    logic [7:0]  a4;
`ifdef MASKED_PAR_SHARED_R_EN
    logic [3:0]  r4;
    logic [0:0]  r1;
`else
    logic [11:0] r4;
    logic [2:0]  r1;
`endif
    logic [11:0] p4;
    logic        ov4;
    logic [2:0]  om4;
    logic [23:0] oc4;
    logic [15:0] cnt4;

    // GF(2) instance with a 2-bit counter to reach saturation
    logic        v1;
    logic [2:0]  m1;
    logic [5:0]  b1;
    logic [1:0]  a1;
    logic [2:0]  p1;
    logic        ov1;
    logic [2:0]  om1;
    logic [5:0]  oc1;
    logic [1:0]  cnt1;

    masked_parallel_hpc3_array #(
        .NUM_SHARES(2), .BIT_WIDTH(4), .NUM_CHANNELS(3), .COUNT_WIDTH(16)
    ) dut4 (
        .in_clock(clk), .in_reset(rst), .in_valid_t0(v4), .in_mask_t0(m4),
        .in_b_t0(b4), .in_a_t1(a4), .in_r(r4), .in_p(p4),
        .out_valid_t2(ov4), .out_mask_t2(om4), .out_c_t2(oc4), .out_count(cnt4)
    );

    masked_parallel_hpc3_array #(
        .NUM_SHARES(2), .BIT_WIDTH(1), .NUM_CHANNELS(3), .COUNT_WIDTH(2)
    ) dut1 (
        .in_clock(clk), .in_reset(rst), .in_valid_t0(v1), .in_mask_t0(m1),
        .in_b_t0(b1), .in_a_t1(a1), .in_r(r1), .in_p(p1),
        .out_valid_t2(ov1), .out_mask_t2(om1), .out_c_t2(oc1), .out_count(cnt1)
    );

    // Model state: pending beat at t1 and expected outputs
    logic        pv4, ev4;
    logic [2:0]  pm4, em4;
    logic [11:0] pb4, ec4;
    logic [15:0] ecnt4;
    logic        pv1, ev1;
    logic [2:0]  pm1, em1, pb1, ec1;
    logic [1:0]  ecnt1;
    logic [31:0] rnd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] gf4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] x, res;
        x   = a;
        res = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) res = res ^ x;
            x = x[3] ? ((x << 1) ^ 4'h3) : (x << 1);
        end
        return res;
    endfunction

    function automatic logic [3:0] rec4(input int k);
        return oc4[k*8 +: 4] ^ oc4[k*8+4 +: 4];
    endfunction

    function automatic logic rec1(input int k);
        return oc1[k*2] ^ oc1[k*2+1];
    endfunction

    // One clock of the GF(16) instance: a new t0 beat plus A for the pending beat
    task automatic cycle4(input logic v, input logic [2:0] m, input logic [11:0] b,
                          input logic [3:0] a);
        logic [31:0] r;
        v4 = v;
        m4 = m;
        for (int k = 0; k < 3; k++) begin
            r = $urandom;
            b4[k*8 +: 8] = {b[k*4 +: 4] ^ r[3:0], r[3:0]};
        end
        r  = $urandom;
        a4 = {a ^ r[3:0], r[3:0]};
        r  = $urandom;
`ifdef MASKED_PAR_SHARED_R_EN
        r4 = r[3:0];
`else
        r4 = r[11:0];
`endif
        p4 = r[23:12];
        ev4 = pv4;
        if (pv4) begin
            em4 = pm4;
            for (int k = 0; k < 3; k++)
                ec4[k*4 +: 4] = pm4[k] ? gf4(a, pb4[k*4 +: 4]) : 4'h0;
            if (ecnt4 != 16'hFFFF) ecnt4 = ecnt4 + 16'd1;
        end
        pv4 = v;
        if (v) begin
            pm4 = m;
            pb4 = b;
        end
        @(posedge clk);
        #1;
        chk("valid4", {31'd0, ov4}, {31'd0, ev4});
        chk("mask4", {29'd0, om4}, {29'd0, em4});
        chk("count4", {16'd0, cnt4}, {16'd0, ecnt4});
        if (ev4) begin
            for (int k = 0; k < 3; k++)
                chk($sformatf("c4_ch%0d", k), {28'd0, rec4(k)}, {28'd0, ec4[k*4 +: 4]});
        end
    endtask

    task automatic cycle1(input logic v, input logic [2:0] m, input logic [2:0] b,
                          input logic a);
        logic [31:0] r;
        r  = $urandom;
        v1 = v;
        m1 = m;
        for (int k = 0; k < 3; k++) b1[k*2 +: 2] = {b[k] ^ r[k], r[k]};
        a1 = {a ^ r[3], r[3]};
`ifdef MASKED_PAR_SHARED_R_EN
        r1 = r[4];
`else
        r1 = r[6:4];
`endif
        p1 = r[9:7];
        ev1 = pv1;
        if (pv1) begin
            em1 = pm1;
            ec1 = pm1 & pb1 & {3{a}};
            if (ecnt1 != 2'b11) ecnt1 = ecnt1 + 2'd1;
        end
        pv1 = v;
        if (v) begin
            pm1 = m;
            pb1 = b;
        end
        @(posedge clk);
        #1;
        chk("valid1", {31'd0, ov1}, {31'd0, ev1});
        chk("mask1", {29'd0, om1}, {29'd0, em1});
        chk("count1", {30'd0, cnt1}, {30'd0, ecnt1});
        if (ev1) chk("c1", {29'd0, rec1(2), rec1(1), rec1(0)}, {29'd0, ec1});
    endtask

    initial begin
        rst = 1'b1;
        v4 = 1'b0; m4 = '0; b4 = '0; a4 = '0; r4 = '0; p4 = '0;
        v1 = 1'b0; m1 = '0; b1 = '0; a1 = '0; r1 = '0; p1 = '0;
        pv4 = 1'b0; ev4 = 1'b0; pm4 = '0; em4 = '0; pb4 = '0; ec4 = '0; ecnt4 = '0;
        pv1 = 1'b0; ev1 = 1'b0; pm1 = '0; em1 = '0; pb1 = '0; ec1 = '0; ecnt1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid4", {31'd0, ov4}, 32'd0);
        chk("rst_mask4", {29'd0, om4}, 32'd0);
        chk("rst_count4", {16'd0, cnt4}, 32'd0);
        chk("rst_c4", {8'd0, oc4}, 32'd0);
        chk("rst_valid1", {31'd0, ov1}, 32'd0);
        chk("rst_count1", {30'd0, cnt1}, 32'd0);
        rst = 1'b0;

        // GF(2): A=1, B={1,0,1}, all channels enabled
        cycle1(1'b1, 3'b111, 3'b101, 1'b0);
        cycle1(1'b0, 3'b000, 3'b000, 1'b1);
        chk("case1_valid", {31'd0, ov1}, 32'd1);
        chk("case1_c", {29'd0, rec1(2), rec1(1), rec1(0)}, 32'h5);
        chk("case1_count", {30'd0, cnt1}, 32'd1);
        // Further beats drive the 2-bit counter into saturation
        cycle1(1'b1, 3'b111, 3'b011, 1'b0);
        cycle1(1'b1, 3'b101, 3'b111, 1'b1);
        cycle1(1'b1, 3'b111, 3'b111, 1'b1);
        cycle1(1'b0, 3'b000, 3'b000, 1'b1);
        chk("sat_count1", {30'd0, cnt1}, 32'd3);
        chk("sat_c1", {29'd0, rec1(2), rec1(1), rec1(0)}, 32'h7);
        cycle1(1'b0, 3'b000, 3'b000, 1'b0);

        // GF(16): A=5, B={3,7,F}, mask 101 -> {F, 0, 6}
        cycle4(1'b1, 3'b101, 12'hF73, 4'h0);
        cycle4(1'b0, 3'b000, 12'h000, 4'h5);
        chk("case2_valid", {31'd0, ov4}, 32'd1);
        chk("case2_mask", {29'd0, om4}, 32'h5);
        chk("case2_ch0", {28'd0, rec4(0)}, 32'hF);
        chk("case2_ch1_raw", {24'd0, oc4[15:8]}, 32'h0);
        chk("case2_ch2", {28'd0, rec4(2)}, 32'h6);

        // Gap pattern; mask offered during the gap must not load
        cycle4(1'b1, 3'b011, 12'h9A2, 4'h0);
        cycle4(1'b0, 3'b111, 12'h123, 4'hB);
        cycle4(1'b1, 3'b110, 12'h4C7, 4'hD);
        chk("gap_mask_hold", {29'd0, om4}, 32'h3);
        cycle4(1'b0, 3'b000, 12'h000, 4'h3);
        cycle4(1'b0, 3'b000, 12'h000, 4'h0);

        // All-zero mask is a counted beat with zero products
        cycle4(1'b1, 3'b000, 12'hFFF, 4'h0);
        cycle4(1'b0, 3'b000, 12'h000, 4'hF);
        chk("zmask_valid", {31'd0, ov4}, 32'd1);
        chk("zmask_c", {8'd0, oc4}, 32'd0);

        // Asynchronous reset while a beat sits in the t1 stage
        cycle4(1'b1, 3'b111, 12'h5A5, 4'h0);
        #2;
        rst = 1'b1;
        v4  = 1'b0;
        #1;
        chk("arst_valid4", {31'd0, ov4}, 32'd0);
        chk("arst_mask4", {29'd0, om4}, 32'd0);
        chk("arst_count4", {16'd0, cnt4}, 32'd0);
        chk("arst_c4", {8'd0, oc4}, 32'd0);
        pv4 = 1'b0; ev4 = 1'b0; em4 = '0; ecnt4 = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) cycle4(1'b0, 3'b000, 12'h000, 4'h7);

        // 100 back-to-back random beats
        for (int n = 0; n < 100; n++) begin
            rnd = $urandom;
            cycle4(1'b1, rnd[2:0], rnd[14:3], rnd[18:15]);
        end
        rnd = $urandom;
        cycle4(1'b0, 3'b000, 12'h000, rnd[3:0]);
        chk("burst_count", {16'd0, cnt4}, 32'd100);
        cycle4(1'b0, 3'b000, 12'h000, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
